// File: rtl/cc_fstall_sched.sv
// cc_fstall_sched: front-end stall scheduler driving fetch-path skid registers
module cc_fstall_sched #(
  parameter int NREQ = 4,
  parameter int SKID_DEPTH = 2,
  parameter int FLUSH_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            except_in,
  input  logic [NREQ-1:0] stall_req,
  input  logic            in_vld,
  output logic            fstall,
  output logic            except,
  output logic            en,
  output logic            out_vld,
  output logic            fetch_hold,
  output logic [1:0]      skid_cnt,
  output logic [NREQ-1:0] stall_owner,
  output logic            skid_ovf,
  output logic [15:0]     stall_cycles
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN, FLUSH} state_t;
  state_t state, nxt;
  logic [3:0] fcnt;
  logic any_req, cap, full, ovf_set;
  logic [1:0] cnt_cap, cnt_nxt;
  logic [NREQ-1:0] owner_lsb;
  always_comb begin
    any_req = |stall_req;
    owner_lsb = stall_req & (~stall_req + NREQ'(1));
    // a beat is captured on entry into STALL as well as while stalled
    cap = in_vld && !except_in && (state == STALL || (state == RUN && any_req));
    full = skid_cnt >= 2'(SKID_DEPTH);
    ovf_set = cap && full;
    cnt_cap = (cap && !full) ? skid_cnt + 2'd1 : skid_cnt;
    nxt = except_in ? FLUSH :
          state == RUN   ? (any_req ? STALL : RUN) :
          state == STALL ? (any_req ? STALL : (cnt_cap != 2'd0 ? DRAIN : RUN)) :
          state == DRAIN ? (any_req ? STALL : (skid_cnt <= 2'd1 ? RUN : DRAIN)) :
          (fcnt == 4'd0 ? (any_req ? STALL : RUN) : FLUSH);
    cnt_nxt = except_in ? 2'd0 : state == DRAIN ? skid_cnt - 2'd1 : cnt_cap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt <= '0;
      fstall <= 1'b0;
      except <= 1'b0;
      en <= 1'b0;
      out_vld <= 1'b0;
      fetch_hold <= 1'b0;
      skid_cnt <= '0;
      stall_owner <= '0;
      skid_ovf <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= nxt;
      fcnt <= except_in ? 4'(FLUSH_CYC - 1) : fcnt - {3'd0, fcnt != 4'd0};
      fstall <= nxt == STALL;
      except <= except_in;
      en <= nxt == RUN ? in_vld : nxt == DRAIN;
      out_vld <= nxt == RUN ? in_vld : nxt == DRAIN;
      fetch_hold <= nxt != RUN;
      skid_cnt <= cnt_nxt;
      stall_owner <= nxt == STALL ? owner_lsb : '0;
      skid_ovf <= skid_ovf | ovf_set;
      if (fstall && !(&stall_cycles)) stall_cycles <= stall_cycles + 16'd1;
    end
  end
endmodule
